// File: rtl/fibonacci_seq_if.sv
// Board-side signal bundle for the Fibonacci generator: switch inputs and
// display-facing outputs, with the generator on the slave side.
interface fibonacci_seq_if #(
  parameter int WIDTH = 12,
  parameter int IW    = 4
);
  logic [1:0]       SW;
  logic [WIDTH-1:0] FIBOUT;
  logic [IW-1:0]    IDX;
  logic             DONE;
  logic             OVF;

  modport master (output SW, input FIBOUT, IDX, DONE, OVF);
  modport slave  (input SW, output FIBOUT, IDX, DONE, OVF);
endinterface

// File: rtl/fibonacci_seq.sv
// Parametrised Fibonacci term generator stepped by an internal clock-enable
// divider; one-shot (stop on end/overflow) or loop (restart with pulses).
module fibonacci_seq #(
  parameter int WIDTH    = 12,
  parameter int N_TERMS  = 15,
  parameter int TICK_DIV = 125000000,
  parameter int MODE     = 0
) (
  input logic           clk,
  fibonacci_seq_if.slave bus
);
  localparam int IW = (N_TERMS > 2) ? $clog2(N_TERMS) : 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_TERMS - 1);
  localparam logic [TW-1:0] LAST_TC  = TW'(TICK_DIV - 1);
  localparam bit LOOP = (MODE != 0);

  logic             rst, pause;
  logic [WIDTH-1:0] prev, curr;
  logic             cov;
  logic [IW-1:0]    idx, idx_nxt;
  logic [TW-1:0]    tcnt;
  logic             done, ovf;
  logic             tick, step;
  logic [WIDTH:0]   sum;

  assign rst     = bus.SW[0];
  assign pause   = bus.SW[1];
  assign tick    = (tcnt == LAST_TC);
  assign step    = tick & ~pause & ~(!LOOP & done);
  assign sum     = {1'b0, prev} + {1'b0, curr};
  assign idx_nxt = idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= '0;
      curr <= {{(WIDTH-1){1'b0}}, 1'b1};
      cov  <= 1'b0;
      idx  <= '0;
      tcnt <= '0;
      done <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      tcnt <= tick ? '0 : tcnt + 1'b1;
      // Loop-mode flags are single-cycle pulses; one-shot flags are sticky.
      if (LOOP) begin
        done <= 1'b0;
        ovf  <= 1'b0;
      end
      if (step) begin
        if (cov) begin
          done <= 1'b1;
          ovf  <= 1'b1;
          if (LOOP) begin
            prev <= '0;
            curr <= {{(WIDTH-1){1'b0}}, 1'b1};
            cov  <= 1'b0;
            idx  <= '0;
          end
        end else if (LOOP && idx == LAST_IDX) begin
          prev <= '0;
          curr <= {{(WIDTH-1){1'b0}}, 1'b1};
          cov  <= 1'b0;
          idx  <= '0;
          done <= 1'b1;
        end else begin
          // curr may already be wrapped; cov keeps it from ever reaching FIBOUT.
          prev <= curr;
          curr <= sum[WIDTH-1:0];
          cov  <= sum[WIDTH];
          idx  <= idx_nxt;
          if (!LOOP && idx_nxt == LAST_IDX) done <= 1'b1;
        end
      end
    end
  end

  assign bus.FIBOUT = prev;
  assign bus.IDX    = idx;
  assign bus.DONE   = done;
  assign bus.OVF    = ovf;
endmodule

// File: tb/tb_fibonacci_seq.sv
// Five generator configurations side by side, checked every cycle against a
// term-index reference model plus directed checks of the documented scenarios.
module tb_fibonacci_seq;
  localparam int NC = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [NC-1:0] pz;

  fibonacci_seq_if #(.WIDTH(12), .IW(4)) if_a ();
  fibonacci_seq_if #(.WIDTH(12), .IW(4)) if_b ();
  fibonacci_seq_if #(.WIDTH(12), .IW(5)) if_c ();
  fibonacci_seq_if #(.WIDTH(12), .IW(5)) if_d ();
  fibonacci_seq_if #(.WIDTH(12), .IW(4)) if_e ();

  assign if_a.SW = {pz[0], rst};
  assign if_b.SW = {pz[1], rst};
  assign if_c.SW = {pz[2], rst};
  assign if_d.SW = {pz[3], rst};
  assign if_e.SW = {pz[4], rst};

  fibonacci_seq #(.WIDTH(12), .N_TERMS(15), .TICK_DIV(1), .MODE(0)) u_a (.clk(clk), .bus(if_a));
  fibonacci_seq #(.WIDTH(12), .N_TERMS(15), .TICK_DIV(1), .MODE(1)) u_b (.clk(clk), .bus(if_b));
  fibonacci_seq #(.WIDTH(12), .N_TERMS(32), .TICK_DIV(1), .MODE(0)) u_c (.clk(clk), .bus(if_c));
  fibonacci_seq #(.WIDTH(12), .N_TERMS(32), .TICK_DIV(1), .MODE(1)) u_d (.clk(clk), .bus(if_d));
  fibonacci_seq #(.WIDTH(12), .N_TERMS(15), .TICK_DIV(4), .MODE(0)) u_e (.clk(clk), .bus(if_e));

  logic [31:0] o_fib [NC];
  logic [31:0] o_idx [NC];
  logic        o_done[NC];
  logic        o_ovf [NC];

  assign o_fib[0] = 32'(if_a.FIBOUT); assign o_idx[0] = 32'(if_a.IDX);
  assign o_fib[1] = 32'(if_b.FIBOUT); assign o_idx[1] = 32'(if_b.IDX);
  assign o_fib[2] = 32'(if_c.FIBOUT); assign o_idx[2] = 32'(if_c.IDX);
  assign o_fib[3] = 32'(if_d.FIBOUT); assign o_idx[3] = 32'(if_d.IDX);
  assign o_fib[4] = 32'(if_e.FIBOUT); assign o_idx[4] = 32'(if_e.IDX);
  assign o_done[0] = if_a.DONE; assign o_ovf[0] = if_a.OVF;
  assign o_done[1] = if_b.DONE; assign o_ovf[1] = if_b.OVF;
  assign o_done[2] = if_c.DONE; assign o_ovf[2] = if_c.OVF;
  assign o_done[3] = if_d.DONE; assign o_ovf[3] = if_d.OVF;
  assign o_done[4] = if_e.DONE; assign o_ovf[4] = if_e.OVF;

  // Configuration table, mirrored from the instance parameters above.
  int cw[NC], cn[NC], cd[NC], cm[NC];

  // Model state: displayed term index n (FIBOUT = F(n)), cycles since last tick.
  int m_n[NC], m_t[NC];
  bit m_done[NC], m_ovf[NC];

  int checks = 0;
  int fails  = 0;

  function automatic longint fib(int n);
    longint a = 0, b = 1, t;
    for (int i = 0; i < n; i++) begin
      t = a + b; a = b; b = t;
    end
    return a;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < NC; k++) begin
      m_n[k] = 0; m_t[k] = 0; m_done[k] = 0; m_ovf[k] = 0;
    end
  endtask

  task automatic m_edge();
    bit tick, unrep;
    if (rst) begin
      m_reset();
      return;
    end
    for (int k = 0; k < NC; k++) begin
      tick = (m_t[k] == cd[k] - 1);
      m_t[k] = tick ? 0 : m_t[k] + 1;
      if (cm[k] == 1) begin m_done[k] = 0; m_ovf[k] = 0; end
      if (tick && !pz[k] && !(cm[k] == 0 && m_done[k])) begin
        unrep = fib(m_n[k] + 1) >= (longint'(1) << cw[k]);
        if (unrep) begin
          m_done[k] = 1; m_ovf[k] = 1;
          if (cm[k] == 1) m_n[k] = 0;
        end else if (cm[k] == 1 && m_n[k] == cn[k] - 1) begin
          m_done[k] = 1; m_n[k] = 0;
        end else begin
          m_n[k]++;
          if (cm[k] == 0 && m_n[k] == cn[k] - 1) m_done[k] = 1;
        end
      end
    end
  endtask

  task automatic check(string tag, int k, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, k, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NC; k++) begin
      check("fib",  k, o_fib[k], 32'(fib(m_n[k])));
      check("idx",  k, o_idx[k], 32'(m_n[k]));
      check("done", k, 32'(o_done[k]), 32'(m_done[k]));
      check("ovf",  k, 32'(o_ovf[k]),  32'(m_ovf[k]));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    m_edge();
    #1;
    check_all();
  endtask

  initial begin
    cw = '{12, 12, 12, 12, 12};
    cn = '{15, 15, 32, 32, 15};
    cd = '{1, 1, 1, 1, 4};
    cm = '{0, 1, 0, 1, 0};
    rst = 1'b1;
    pz  = '0;
    #1;
    m_reset();
    check_all();
    cyc();
    cyc();
    rst = 1'b0;

    for (int i = 1; i <= 40; i++) begin
      cyc();
      case (i)
        14: begin
          check("A_fib377", 0, o_fib[0], 377);
          check("A_idx14",  0, o_idx[0], 14);
          check("A_done",   0, 32'(o_done[0]), 1);
          check("B_fib377", 1, o_fib[1], 377);
          check("B_nodone", 1, 32'(o_done[1]), 0);
        end
        15: begin
          check("B_restart", 1, o_fib[1], 0);
          check("B_dpulse",  1, 32'(o_done[1]), 1);
          check("B_noovf",   1, 32'(o_ovf[1]), 0);
        end
        16: begin
          check("B_dclear", 1, 32'(o_done[1]), 0);
          check("B_fib1",   1, o_fib[1], 1);
        end
        18: begin
          check("C_fib2584", 2, o_fib[2], 2584);
          check("C_idx18",   2, o_idx[2], 18);
          check("C_nodone",  2, 32'(o_done[2]), 0);
        end
        19: begin
          check("C_hold2584", 2, o_fib[2], 2584);
          check("C_done",     2, 32'(o_done[2]), 1);
          check("C_ovf",      2, 32'(o_ovf[2]), 1);
          check("D_restart",  3, o_fib[3], 0);
          check("D_dpulse",   3, 32'(o_done[3]), 1);
          check("D_opulse",   3, 32'(o_ovf[3]), 1);
        end
        20: begin
          check("D_oclear", 3, 32'(o_ovf[3]), 0);
          check("E_fib5",   4, o_fib[4], 5);
          check("A_hold",   0, o_fib[0], 377);
        end
        31: check("E_paused5", 4, o_fib[4], 5);
        32: check("E_fib8",    4, o_fib[4], 8);
        default: ;
      endcase
      if (i == 20) pz[4] = 1'b1;
      if (i == 28) pz[4] = 1'b0;
    end

    // Asynchronous reset between edges while E shows 21.
    check("E_fib21", 4, o_fib[4], 21);
    #2 rst = 1'b1;
    #1;
    m_reset();
    check("E_async_fib", 4, o_fib[4], 0);
    check("C_async_done", 2, 32'(o_done[2]), 0);
    check_all();
    cyc();
    cyc();
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      if (i == 3) check("E_wait", 4, o_fib[4], 0);
      if (i == 4) check("E_first", 4, o_fib[4], 1);
    end

    // Randomised pauses and occasional resets.
    repeat (600) begin
      pz  = NC'($urandom);
      rst = ($urandom_range(0, 63) == 0);
      cyc();
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
